md_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide execute unit. It sits directly downstream of the decode control unit.
- It consumes the decoded alu_op codes 10..17 together with the forwarded operands.
- It returns a 32-bit result plus destination tag. busy stalls the pipeline while an operation runs; done writes the result back.

---
 rtl/md_pkg.sv | 27 ++
 rtl/md_unit_if.sv | 18 +
 rtl/md_div_iter.sv | 56 +++++
 rtl/md_unit.sv | 132 +++++++++++++
 tb/tb_md_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared alu_op codes, FSM state type and result constants for the RV32M
// multiply/divide unit.
package md_pkg;

  localparam logic [4:0] MD_MUL    = 5'd10;
  localparam logic [4:0] MD_MULH   = 5'd11;
  localparam logic [4:0] MD_MULHU  = 5'd12;
  localparam logic [4:0] MD_MULHSU = 5'd13;
  localparam logic [4:0] MD_DIVU   = 5'd14;
  localparam logic [4:0] MD_REMU   = 5'd15;
  localparam logic [4:0] MD_DIV    = 5'd16;
  localparam logic [4:0] MD_REM    = 5'd17;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} md_state_e;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op >= MD_MUL) && (op <= MD_REM);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= MD_DIVU) && (op <= MD_REM);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between the decode stage (master) and md_unit (slave).
interface md_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic            flush;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_addr_i;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_addr_o;

  modport master (output start, flush, alu_op, op_a, op_b, rd_addr_i,
                  input  busy, done, result, rd_addr_o);
  modport slave  (input  start, flush, alu_op, op_a, op_b, rd_addr_i,
                  output busy, done, result, rd_addr_o);
endinterface

// File: rtl/md_div_iter.sv
// Restoring divider datapath on unsigned magnitudes: load initialises the
// registers, each step retires one quotient bit, last_iter flags the final step.
module md_div_iter #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last_iter
);
  localparam int CW = $clog2(DIV_ITERS);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      // A clear top bit of diff means the trial subtraction did not borrow.
      if (!diff[XLEN+1]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last_iter = (cnt_q == CW'(DIV_ITERS - 1));
endmodule

// File: rtl/md_unit.sv
// RV32M multiply/divide execute unit: single-cycle registered multiply,
// iterative restoring divide. Optional MD_UNIT_EARLY_OUT_EN shortcuts
// divide-by-zero and signed overflow past the divide iterations.
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic       clk,
  input  logic       rst,
  md_unit_if.slave   bus
);
  md_state_e         state_q, state_d;
  logic [4:0]        op_q, rd_q, rd_out_q;
  logic [XLEN-1:0]   a_q, b_q, result_q, fin_result;
  logic [2*XLEN-1:0] prod_q, wa, wb, prod;
  logic              first_q, busy, accept;
  logic              sign_a, sign_b, signed_div, neg_a, neg_b, b_zero, ovf;
  logic [XLEN-1:0]   mag_a, mag_b, quo, rem;
  logic              div_load, div_step, last_iter;

  assign busy   = (state_q == MUL) || (state_q == DIV);
  assign accept = bus.start && !busy && !bus.flush && is_md_op(bus.alu_op);

  // 33x33 signed product, widened to the full 64-bit result before multiplying.
  always_comb begin
    sign_a = (op_q == MD_MUL) || (op_q == MD_MULH) || (op_q == MD_MULHSU);
    sign_b = (op_q == MD_MUL) || (op_q == MD_MULH);
    wa     = {{XLEN{sign_a & a_q[XLEN-1]}}, a_q};
    wb     = {{XLEN{sign_b & b_q[XLEN-1]}}, b_q};
    prod   = wa * wb;
  end

  always_comb begin
    signed_div = (op_q == MD_DIV) || (op_q == MD_REM);
    neg_a      = signed_div & a_q[XLEN-1];
    neg_b      = signed_div & b_q[XLEN-1];
    mag_a      = neg_a ? -a_q : a_q;
    mag_b      = neg_b ? -b_q : b_q;
    b_zero     = (b_q == '0);
    ovf        = signed_div && (a_q == INT_MIN) && (b_q == '1);
  end

  assign div_load = (state_q == DIV) && first_q;
  assign div_step = (state_q == DIV) && !first_q;

  md_div_iter #(.XLEN(XLEN), .DIV_ITERS(DIV_ITERS)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem),
    .last_iter (last_iter)
  );

  always_comb begin
    fin_result = '0;
    unique case (op_q)
      MD_MUL:                      fin_result = prod_q[XLEN-1:0];
      MD_MULH, MD_MULHU, MD_MULHSU: fin_result = prod_q[2*XLEN-1:XLEN];
      MD_DIVU: fin_result = b_zero ? DIV_BY_ZERO_Q : quo;
      MD_REMU: fin_result = b_zero ? a_q : rem;
      MD_DIV:  fin_result = b_zero ? DIV_BY_ZERO_Q :
                            ovf    ? INT_MIN :
                            (neg_a ^ neg_b) ? -quo : quo;
      MD_REM:  fin_result = b_zero ? a_q :
                            ovf    ? '0 :
                            neg_a  ? -rem : rem;
      default: fin_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = is_div_op(bus.alu_op) ? DIV : MUL;
      MUL:  state_d = FIN;
      DIV: begin
`ifdef MD_UNIT_EARLY_OUT_EN
        // Special cases are recognised in the load cycle and never iterate.
        if (first_q && (b_zero || ovf)) state_d = FIN;
`endif
        if (!first_q && last_iter) state_d = FIN;
      end
      FIN: state_d = accept ? (is_div_op(bus.alu_op) ? DIV : MUL) : IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      first_q  <= 1'b0;
      prod_q   <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      if (div_load) first_q <= 1'b0;
      if (accept) begin
        op_q    <= bus.alu_op;
        a_q     <= bus.op_a;
        b_q     <= bus.op_b;
        rd_q    <= bus.rd_addr_i;
        first_q <= 1'b1;
      end
      if (state_q == MUL) prod_q <= prod;
      if (state_q == FIN) begin
        result_q <= fin_result;
        rd_out_q <= rd_q;
      end
    end
  end

  // The finished value is presented combinationally in FIN and held afterwards.
  assign bus.busy      = busy;
  assign bus.done      = (state_q == FIN);
  assign bus.result    = (state_q == FIN) ? fin_result : result_q;
  assign bus.rd_addr_o = (state_q == FIN) ? rd_q : rd_out_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random
// operations against an arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  md_unit_if #(.XLEN(32)) bus ();

  md_unit #(.XLEN(32), .DIV_ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    int          sai, sbi;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    sai = $signed(a);
    sbi = $signed(b);
    up  = {32'h0, a} * {32'h0, b};
    ovf = (a == INT_MIN) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHU:  return up[63:32];
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REMU:   return (b == 0) ? a : a % b;
      MD_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? INT_MIN : 32'(sai / sbi);
      MD_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sai % sbi);
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < MD_DIVU) return 2;
`ifdef MD_UNIT_EARLY_OUT_EN
    if (b == 0) return 2;
    if ((op == MD_DIV || op == MD_REM) && a == INT_MIN && b == 32'hFFFF_FFFF) return 2;
`endif
    return 34;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit junk, input string tag);
    int          k;
    bit          seen, busy_ok;
    logic [31:0] exp_r;
    int          exp_l;
    exp_r = ref_result(op, a, b);
    exp_l = ref_lat(op, a, b);
    bus.start = 1'b1; bus.alu_op = op; bus.op_a = a; bus.op_b = b; bus.rd_addr_i = rd;
    @(posedge clk); #1;
    if (junk) begin
      bus.alu_op = MD_MULHU; bus.op_a = ~a; bus.op_b = b ^ 32'h5A5A_5A5A; bus.rd_addr_i = ~rd;
    end else begin
      bus.start = 1'b0;
    end
    busy_ok = 1'b1; seen = 1'b0; k = 0;
    while (k < 60 && !seen) begin
      @(negedge clk);
      k++;
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(k), 32'(exp_l));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_result"}, bus.result, exp_r);
    chk({tag, "_rd"}, 32'(bus.rd_addr_o), 32'(rd));
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    bit d;
    d = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) d = 1'b1;
    end
    chk(tag, 32'(d), 32'd0);
  endtask

  initial begin
    logic [31:0] prev_res, a, b;
    logic [4:0]  prev_rd, op;
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.alu_op = '0;
    bus.op_a = '0; bus.op_b = '0; bus.rd_addr_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_rd", 32'(bus.rd_addr_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0, "mulh_m1");
    do_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, "mulhu_max");
    do_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, "mulhsu_m1");
    do_op(MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0, "mul_m1");
    @(negedge clk);
    chk("hold_result", bus.result, 32'd1);
    chk("hold_rd", 32'(bus.rd_addr_o), 32'd4);
    chk("hold_done_low", 32'(bus.done), 32'd0);

    do_op(MD_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0, "div_m7_2");
    do_op(MD_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0, "rem_m7_2");
    do_op(MD_DIVU, 32'd100, 32'd7, 5'd7, 1'b0, "divu_100_7");
    do_op(MD_REMU, 32'd100, 32'd7, 5'd8, 1'b0, "remu_100_7");
    do_op(MD_DIVU, 32'h1234, 32'd0, 5'd9, 1'b0, "divu_by0");
    do_op(MD_REMU, 32'h1234, 32'd0, 5'd10, 1'b0, "remu_by0");
    do_op(MD_DIV,  INT_MIN, 32'hFFFF_FFFF, 5'd11, 1'b0, "div_ovf");
    do_op(MD_REM,  INT_MIN, 32'hFFFF_FFFF, 5'd12, 1'b0, "rem_ovf");
    do_op(MD_DIV,  32'd9, 32'd0, 5'd13, 1'b0, "div_by0");
    do_op(MD_REM,  32'hFFFF_FF00, 32'd0, 5'd14, 1'b0, "rem_by0");

    do_op(MD_DIVU, 32'd1000, 32'd3, 5'd15, 1'b1, "divu_junk_start");
    do_op(MD_MUL, 32'd6, 32'd7, 5'd16, 1'b1, "mul_junk_start");
    do_op(MD_MUL, 32'd6, 32'd7, 5'd17, 1'b0, "b2b_first");
    do_op(MD_MUL, 32'd9, 32'd9, 5'd18, 1'b0, "b2b_second");

    // Flush a divide in flight.
    @(negedge clk);
    prev_res = bus.result; prev_rd = bus.rd_addr_o;
    bus.start = 1'b1; bus.alu_op = MD_DIV; bus.op_a = 32'h1000; bus.op_b = 32'd3; bus.rd_addr_i = 5'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_done", 32'(bus.done), 32'd0);
    chk("flush_result", bus.result, prev_res);
    chk("flush_rd", 32'(bus.rd_addr_o), 32'(prev_rd));
    watch_no_done("flush_no_done", 40);
    do_op(MD_MUL, 32'd3, 32'd5, 5'd21, 1'b0, "mul_after_flush");

    // Flush and start together: nothing accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.alu_op = MD_MUL; bus.op_a = 32'd2; bus.op_b = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", 32'(bus.busy), 32'd0);
    watch_no_done("flush_start_no_done", 4);

    // Reset in the middle of a divide.
    bus.start = 1'b1; bus.alu_op = MD_DIVU; bus.op_a = 32'd77; bus.op_b = 32'd5; bus.rd_addr_i = 5'd22;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_rd", 32'(bus.rd_addr_o), 32'd0);
    watch_no_done("midrst_no_done", 40);

    // Out-of-range alu_op is ignored.
    bus.start = 1'b1; bus.alu_op = 5'd4; bus.op_a = 32'd1; bus.op_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("badop_busy", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b0;
    watch_no_done("badop_no_done", 3);

    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(10, 17));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = INT_MIN; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      do_op(op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
